// File: rtl/sram_rr_arbiter_if.sv
// Request bus and SRAM pin bundle for sram_rr_arbiter.
// slave = arbiter side, master = requesters plus SRAM side.
interface sram_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic [AW-1:0]      sram_a;
    logic               sram_cs_n;
    logic               sram_we_n;
    logic               sram_oe_n;
    logic [DW-1:0]      sram_dout;
    logic               sram_dout_en;
    logic [DW-1:0]      sram_din;

    modport slave (
        input  req, req_we, req_addr, req_wdata, sram_din,
        output gnt, rvalid, rdata, sram_a, sram_cs_n,
        output sram_we_n, sram_oe_n, sram_dout, sram_dout_en
    );

    modport master (
        output req, req_we, req_addr, req_wdata, sram_din,
        input  gnt, rvalid, rdata, sram_a, sram_cs_n,
        input  sram_we_n, sram_oe_n, sram_dout, sram_dout_en
    );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NREQ requesters.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module sram_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_rr_arbiter_if.slave      io
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CMD    = 2'd1,
        S_RDWAIT = 2'd2
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_sel;
    logic            r_we;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_rvalid;
    logic [DW-1:0]   r_rdata;
    logic [AW-1:0]   r_sram_a;
    logic            r_cs_n;
    logic            r_we_n;
    logic            r_oe_n;
    logic [DW-1:0]   r_dout;
    logic            r_dout_en;

    logic            w_any;
    logic [IW-1:0]   w_win;
    logic            w_we;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_wdata;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    // Lowest-index request wins; scan downward so index 0 is assigned last.
    always_comb begin
        w_win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (io.req[i]) begin
                w_win = IW'(i);
            end
        end
        w_any = |io.req;
    end
`else
    logic [IW-1:0] r_ptr;
    logic          w_found_hi;
    logic          w_found_lo;
    logic [IW-1:0] w_win_hi;
    logic [IW-1:0] w_win_lo;

    // First request above the pointer wins, else wrap to the lowest at/below it.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (io.req[i] && (IW'(i) > r_ptr) && !w_found_hi) begin
                w_found_hi = 1'b1;
                w_win_hi   = IW'(i);
            end
            if (io.req[i] && (IW'(i) <= r_ptr) && !w_found_lo) begin
                w_found_lo = 1'b1;
                w_win_lo   = IW'(i);
            end
        end
        w_win = w_found_hi ? w_win_hi : w_win_lo;
        w_any = w_found_hi | w_found_lo;
    end

    // Pointer tracks the last winner so it becomes lowest priority next round.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= IW'(NREQ - 1);
        end else if (r_state == S_IDLE && w_any) begin
            r_ptr <= w_win;
        end
    end
`endif

    // Select the winner's command fields from the flat request buses.
    always_comb begin
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IW'(i)) begin
                w_we    = io.req_we[i];
                w_addr  = io.req_addr[i*AW +: AW];
                w_wdata = io.req_wdata[i*DW +: DW];
            end
        end
    end

    // Access sequencer; every output is registered and defaults to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_we      <= 1'b0;
            r_gnt     <= '0;
            r_rvalid  <= '0;
            r_rdata   <= '0;
            r_sram_a  <= '0;
            r_cs_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_dout    <= '0;
            r_dout_en <= 1'b0;
        end else begin
            r_gnt     <= '0;
            r_rvalid  <= '0;
            r_cs_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_dout_en <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_sel     <= w_win;
                        r_we      <= w_we;
                        r_gnt     <= NREQ'(1) << w_win;
                        r_cs_n    <= 1'b0;
                        r_sram_a  <= w_addr;
                        r_we_n    <= ~w_we;
                        r_oe_n    <= w_we;
                        r_dout_en <= w_we;
                        if (w_we) begin
                            r_dout <= w_wdata;
                        end
                        r_state   <= S_CMD;
                    end
                end
                S_CMD: begin
                    r_state <= r_we ? S_IDLE : S_RDWAIT;
                end
                S_RDWAIT: begin
                    r_rdata  <= io.sram_din;
                    r_rvalid <= NREQ'(1) << r_sel;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io.gnt          = r_gnt;
    assign io.rvalid       = r_rvalid;
    assign io.rdata        = r_rdata;
    assign io.sram_a       = r_sram_a;
    assign io.sram_dout    = r_dout;
    // Reset forces the strobes idle at once so an in-flight write is dropped.
    assign io.sram_cs_n    = r_cs_n | rst;
    assign io.sram_we_n    = r_we_n | rst;
    assign io.sram_oe_n    = r_oe_n | rst;
    assign io.sram_dout_en = r_dout_en & ~rst;
endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with a behavioural SRAM.
// Honours SRAM_ARB_FIXED_PRIO_EN for the priority scenario.
module tb_sram_rr_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sram_rr_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

    sram_rr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    // SRAM model: write at clock edge, registered read data
    logic [DW-1:0] mem [0:15];
    logic [DW-1:0] q = '0;
    logic          mem_clr = 1'b0;
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else begin
            if (!bus.sram_cs_n && !bus.sram_we_n) mem[bus.sram_a] <= bus.sram_dout;
            if (!bus.sram_cs_n && !bus.sram_oe_n) q <= mem[bus.sram_a];
        end
    end
    assign bus.sram_din = q;

    // Protocol monitors
    int onehot_viol = 0;
    int strobe_viol = 0;
    int rv2_cnt = 0;
    always @(negedge clk) begin
        if ($countones(bus.gnt) > 1 || $countones(bus.rvalid) > 1) onehot_viol++;
        if (!bus.sram_cs_n && !bus.sram_we_n && bus.gnt == '0) strobe_viol++;
        if (bus.rvalid[2]) rv2_cnt++;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
        rst = 1'b1;
        mem_clr = 1'b1;
        cyc();
        mem_clr = 1'b0;
        cyc();
        checks++;
        if (bus.gnt !== 4'b0 || bus.rvalid !== 4'b0 || bus.rdata !== 8'h00) begin
            errors++;
            $display("FAIL rst_out got gnt=%b rvalid=%b rdata=%h exp 0000 0000 00", bus.gnt, bus.rvalid, bus.rdata);
        end
        checks++;
        if ({bus.sram_cs_n, bus.sram_we_n, bus.sram_oe_n, bus.sram_dout_en} !== 4'b1110) begin
            errors++;
            $display("FAIL rst_ctl got cs/we/oe/en=%b exp 1110", {bus.sram_cs_n, bus.sram_we_n, bus.sram_oe_n, bus.sram_dout_en});
        end
        checks++;
        if (bus.sram_a !== 4'h0 || bus.sram_dout !== 8'h00) begin
            errors++;
            $display("FAIL rst_bus got a=%h dout=%h exp 0 00", bus.sram_a, bus.sram_dout);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        bus.req = 4'b0001; bus.req_we[0] = 1'b1;
        bus.req_addr[3:0] = 4'd3; bus.req_wdata[7:0] = 8'hA5;
        cyc();
        checks++;
        if (bus.gnt !== 4'b0001) begin
            errors++; $display("FAIL wr_gnt got %b exp 0001", bus.gnt);
        end
        checks++;
        if ({bus.sram_cs_n, bus.sram_we_n, bus.sram_oe_n, bus.sram_dout_en} !== 4'b0011 ||
            bus.sram_a !== 4'd3 || bus.sram_dout !== 8'hA5) begin
            errors++;
            $display("FAIL wr_strobe got ctl=%b a=%h d=%h exp 0011 3 a5",
                     {bus.sram_cs_n, bus.sram_we_n, bus.sram_oe_n, bus.sram_dout_en}, bus.sram_a, bus.sram_dout);
        end
        bus.req = '0;
        cyc();
        checks++;
        if (bus.gnt !== 4'b0 || bus.sram_cs_n !== 1'b1 || bus.sram_dout_en !== 1'b0 || mem[3] !== 8'hA5) begin
            errors++;
            $display("FAIL wr_done got gnt=%b cs_n=%b en=%b mem3=%h exp 0000 1 0 a5", bus.gnt, bus.sram_cs_n, bus.sram_dout_en, mem[3]);
        end
        bus.req = 4'b0001; bus.req_we[0] = 1'b0;
        cyc();
        checks++;
        if (bus.gnt !== 4'b0001 ||
            {bus.sram_cs_n, bus.sram_we_n, bus.sram_oe_n, bus.sram_dout_en} !== 4'b0100) begin
            errors++;
            $display("FAIL rd_cmd got gnt=%b ctl=%b exp 0001 0100", bus.gnt, {bus.sram_cs_n, bus.sram_we_n, bus.sram_oe_n, bus.sram_dout_en});
        end
        bus.req = '0;
        cyc();
        checks++;
        if (bus.rvalid !== 4'b0 || bus.sram_cs_n !== 1'b1) begin
            errors++; $display("FAIL rd_wait got rvalid=%b cs_n=%b exp 0000 1", bus.rvalid, bus.sram_cs_n);
        end
        cyc();
        checks++;
        if (bus.rvalid !== 4'b0001 || bus.rdata !== 8'hA5) begin
            errors++; $display("FAIL rd_ret got rvalid=%b rdata=%h exp 0001 a5", bus.rvalid, bus.rdata);
        end
        cyc();
        checks++;
        if (bus.rvalid !== 4'b0 || bus.rdata !== 8'hA5) begin
            errors++; $display("FAIL rd_hold got rvalid=%b rdata=%h exp 0000 a5", bus.rvalid, bus.rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [0:8];
        exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                  4'b0000, 4'b1000, 4'b0000, 4'b0001};
        do_reset();
        pl_en = 1'b1; pl_addr = 4'd4; pl_data = 8'hEE;
        cyc();
        pl_en = 1'b0;
        bus.req_we = 4'b1111;
        bus.req_addr = {4'd7, 4'd6, 4'd5, 4'd4};
        bus.req_wdata = {8'd3, 8'd2, 8'd1, 8'd0};
        bus.req = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            cyc();
            checks++;
            if (bus.gnt !== exp_g[k]) begin
                errors++; $display("FAIL rr_gnt step %0d got %b exp %b", k, bus.gnt, exp_g[k]);
            end
        end
        bus.req = '0;
        cyc();
        checks++;
        if (mem[4] !== 8'd0 || mem[5] !== 8'd1 || mem[6] !== 8'd2 || mem[7] !== 8'd3) begin
            errors++;
            $display("FAIL rr_mem got %h %h %h %h exp 00 01 02 03", mem[4], mem[5], mem[6], mem[7]);
        end
    endtask

    task automatic test_cross_read();
        int rv2_start;
        rv2_start = rv2_cnt;
        do_reset();
        bus.req_we = 4'b0100;
        bus.req_addr[8 +: 4] = 4'd15; bus.req_wdata[16 +: 8] = 8'hFF;
        bus.req = 4'b0100;
        cyc();
        checks++;
        if (bus.gnt !== 4'b0100 || bus.sram_a !== 4'd15 || bus.sram_we_n !== 1'b0) begin
            errors++; $display("FAIL x_wr got gnt=%b a=%h we_n=%b exp 0100 f 0", bus.gnt, bus.sram_a, bus.sram_we_n);
        end
        bus.req = '0;
        cyc();
        bus.req_we = 4'b0000;
        bus.req_addr[4 +: 4] = 4'd15;
        bus.req = 4'b0010;
        cyc();
        checks++;
        if (bus.gnt !== 4'b0010 || bus.sram_a !== 4'd15 || bus.sram_oe_n !== 1'b0) begin
            errors++; $display("FAIL x_rd got gnt=%b a=%h oe_n=%b exp 0010 f 0", bus.gnt, bus.sram_a, bus.sram_oe_n);
        end
        bus.req = '0;
        cyc();
        cyc();
        checks++;
        if (bus.rvalid !== 4'b0010 || bus.rdata !== 8'hFF) begin
            errors++; $display("FAIL x_ret got rvalid=%b rdata=%h exp 0010 ff", bus.rvalid, bus.rdata);
        end
        cyc();
        checks++;
        if (rv2_cnt !== rv2_start) begin
            errors++; $display("FAIL x_rv2 got %0d rvalid[2] pulses exp 0", rv2_cnt - rv2_start);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        bus.req_we = 4'b0000;
        bus.req_addr[12 +: 4] = 4'd5;
        bus.req = 4'b1000;
        cyc();
        checks++;
        if (bus.gnt !== 4'b1000) begin
            errors++; $display("FAIL mr_gnt3 got %b exp 1000", bus.gnt);
        end
        bus.req = '0;
        cyc();
        rst = 1'b1;
        cyc();
        checks++;
        if (bus.rvalid !== 4'b0 || bus.rdata !== 8'h00 || bus.gnt !== 4'b0 || bus.sram_cs_n !== 1'b1) begin
            errors++;
            $display("FAIL mr_rst got rvalid=%b rdata=%h gnt=%b cs_n=%b exp 0000 00 0000 1", bus.rvalid, bus.rdata, bus.gnt, bus.sram_cs_n);
        end
        rst = 1'b0;
        bus.req_we = 4'b0001;
        bus.req_addr[3:0] = 4'd2;
        bus.req = 4'b1001;
        cyc();
        checks++;
        if (bus.gnt !== 4'b0001 || bus.rvalid !== 4'b0) begin
            errors++; $display("FAIL mr_next got gnt=%b rvalid=%b exp 0001 0000", bus.gnt, bus.rvalid);
        end
        bus.req = '0;
        cyc();
        cyc();
        // reset inside a write command must cancel the write
        bus.req_we = 4'b0010;
        bus.req_addr[4 +: 4] = 4'd9; bus.req_wdata[8 +: 8] = 8'h5A;
        bus.req = 4'b0010;
        cyc();
        checks++;
        if (bus.gnt !== 4'b0010) begin
            errors++; $display("FAIL wc_gnt got %b exp 0010", bus.gnt);
        end
        bus.req = '0;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.sram_cs_n, bus.sram_we_n, bus.sram_dout_en} !== 3'b110) begin
            errors++; $display("FAIL wc_force got cs/we/en=%b exp 110", {bus.sram_cs_n, bus.sram_we_n, bus.sram_dout_en});
        end
        cyc();
        rst = 1'b0;
        checks++;
        if (mem[9] !== 8'h00) begin
            errors++; $display("FAIL wc_mem got %h exp 00", mem[9]);
        end
    endtask

    task automatic test_priority();
        logic [3:0] exp_g [0:7];
`ifdef SRAM_ARB_FIXED_PRIO_EN
        exp_g = '{4'b0001, 4'b0000, 4'b0001, 4'b0000,
                  4'b0001, 4'b0000, 4'b0001, 4'b0000};
`else
        exp_g = '{4'b0001, 4'b0000, 4'b0100, 4'b0000,
                  4'b0001, 4'b0000, 4'b0100, 4'b0000};
`endif
        do_reset();
        bus.req_we = 4'b0101;
        bus.req_addr[3:0] = 4'd1; bus.req_addr[8 +: 4] = 4'd2;
        bus.req = 4'b0101;
        for (int k = 0; k < 7; k++) begin
            cyc();
            checks++;
            if (bus.gnt !== exp_g[k]) begin
                errors++; $display("FAIL pr_gnt step %0d got %b exp %b", k, bus.gnt, exp_g[k]);
            end
        end
        bus.req = 4'b0100;
        cyc();
        checks++;
        if (bus.gnt !== exp_g[7]) begin
            errors++; $display("FAIL pr_gap got %b exp %b", bus.gnt, exp_g[7]);
        end
        cyc();
        checks++;
        if (bus.gnt !== 4'b0100) begin
            errors++; $display("FAIL pr_drop got %b exp 0100", bus.gnt);
        end
        bus.req = '0;
        cyc();
        cyc();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_cross_read();
        test_reset_mid_op();
        test_priority();
        checks++;
        if (onehot_viol !== 0) begin
            errors++; $display("FAIL onehot got %0d violations exp 0", onehot_viol);
        end
        checks++;
        if (strobe_viol !== 0) begin
            errors++; $display("FAIL strobe got %0d violations exp 0", strobe_viol);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
